// File: rtl/my_pulse_replayer_pkg.sv
// rp_defs: shared state encodings and sizing helper for the pulse replayer
package rp_defs;
  typedef enum logic [1:0] {
    RP_IDLE = 2'd0,
    RP_ON   = 2'd1,
    RP_GAP  = 2'd2
  } rp_state_t;
  function automatic int rp_clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/my_pulse_replayer_sat_updown_counter.sv
// my_sat_updown_counter: saturating up/down backlog counter with sticky overflow
module my_sat_updown_counter import rp_defs::*; #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         overflow
);
  logic full, empty;
  assign full  = &count;
  assign empty = ~|count;
  // simultaneous inc/dec cancel; an inc that would wrap is dropped and flagged
  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      count    <= (inc & ~dec & ~full) ? count + 1'b1 : (dec & ~inc & ~empty) ? count - 1'b1 : count;
      overflow <= overflow | (inc & ~dec & full);
    end
  end
endmodule

// File: rtl/my_pulse_replayer.sv
// my_pulse_replayer: stretches event pulses into fixed blinks, replaying backlog in order
module my_pulse_replayer import rp_defs::*; #(
  parameter int ON_CYCLES  = 4,
  parameter int GAP_CYCLES = 2,
  parameter int PEND_WIDTH = 2
) (
  input  logic                  rp_clock,
  input  logic                  rp_reset,
  input  logic                  pulse_in,
  output logic                  rp_output,
  output logic                  rp_busy,
  output logic [PEND_WIDTH-1:0] rp_pending,
  output logic                  rp_overflow
);
  localparam int MX = ON_CYCLES > GAP_CYCLES ? ON_CYCLES : GAP_CYCLES;
  localparam int CW = rp_clog2(MX) < 1 ? 1 : rp_clog2(MX);
  localparam logic [CW-1:0] ON_LOAD  = CW'(ON_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CYCLES - 1);
  rp_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic cnt_z, pend_nz, gap_end, restart, inc, dec;
  assign cnt_z   = cnt == '0;
  assign pend_nz = |rp_pending;
  assign gap_end = state == RP_GAP && cnt_z;
  assign restart = pend_nz | pulse_in;
  assign dec     = gap_end & pend_nz;
  assign inc     = pulse_in & (state != RP_IDLE) & ~(gap_end & ~pend_nz);
  assign rp_output = state == RP_ON;
  assign rp_busy   = state != RP_IDLE;
  // state and down-counter register
  always_ff @(posedge rp_clock) begin
    if (rp_reset) begin
      state <= RP_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end
  // blink sequencing: IDLE -> ON -> GAP -> (ON again while work remains | IDLE)
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      RP_IDLE: begin
        state_n = pulse_in ? RP_ON : RP_IDLE;
        cnt_n   = pulse_in ? ON_LOAD : cnt;
      end
      RP_ON: begin
        state_n = cnt_z ? RP_GAP : RP_ON;
        cnt_n   = cnt_z ? GAP_LOAD : cnt - 1'b1;
      end
      RP_GAP: begin
        state_n = !cnt_z ? RP_GAP : restart ? RP_ON : RP_IDLE;
        cnt_n   = !cnt_z ? cnt - 1'b1 : restart ? ON_LOAD : '0;
      end
      default: begin
        state_n = RP_IDLE;
        cnt_n   = '0;
      end
    endcase
  end
  my_sat_updown_counter #(.W(PEND_WIDTH)) u_pend (
    .clk      (rp_clock),
    .rst      (rp_reset),
    .inc      (inc),
    .dec      (dec),
    .count    (rp_pending),
    .overflow (rp_overflow)
  );
endmodule

// File: tb/tb_my_pulse_replayer.sv
// tb_my_pulse_replayer: directed and random checks against a blink-phase reference model
module tb_my_pulse_replayer;
  logic clk = 0, rst = 0, pulse = 0;
  logic out_a, busy_a, ovf_a, out_b, busy_b, ovf_b;
  logic [1:0] pend_a, pend_b;
  int checks = 0, passed = 0, blinks = 0;
  logic prev_a = 0;
  localparam int MAXP = 3;
  int on_c[2]  = '{4, 1};
  int gap_c[2] = '{2, 1};
  int ph[2]    = '{0, 0};
  int pend[2]  = '{0, 0};
  int ovf[2]   = '{0, 0};

  always #5 clk = ~clk;

  my_pulse_replayer dut_a (
    .rp_clock(clk), .rp_reset(rst), .pulse_in(pulse),
    .rp_output(out_a), .rp_busy(busy_a), .rp_pending(pend_a), .rp_overflow(ovf_a)
  );
  my_pulse_replayer #(.ON_CYCLES(1), .GAP_CYCLES(1), .PEND_WIDTH(2)) dut_b (
    .rp_clock(clk), .rp_reset(rst), .pulse_in(pulse),
    .rp_output(out_b), .rp_busy(busy_b), .rp_pending(pend_b), .rp_overflow(ovf_b)
  );

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
  endtask

  // ph counts cycles since the current blink began (0 = idle, last = ON+GAP)
  task automatic model_step(input int i, input bit p, input bit r);
    bit last, cons, direct;
    if (r) begin
      ph[i] = 0; pend[i] = 0; ovf[i] = 0;
      return;
    end
    if (ph[i] == 0) begin
      if (p) ph[i] = 1;
      return;
    end
    last   = ph[i] == on_c[i] + gap_c[i];
    cons   = last && pend[i] > 0;
    direct = last && pend[i] == 0 && p;
    if (p && !direct && !cons) begin
      if (pend[i] == MAXP) ovf[i] = 1;
      else pend[i]++;
    end else if (cons && !p) pend[i]--;
    ph[i] = last ? ((cons || direct) ? 1 : 0) : ph[i] + 1;
  endtask

  task automatic step(input bit p, input bit r);
    pulse = p;
    rst = r;
    @(posedge clk);
    model_step(0, p, r);
    model_step(1, p, r);
    #1;
    check("out_a",  4'(out_a),  4'(ph[0] >= 1 && ph[0] <= on_c[0]));
    check("busy_a", 4'(busy_a), 4'(ph[0] != 0));
    check("pend_a", 4'(pend_a), 4'(pend[0]));
    check("ovf_a",  4'(ovf_a),  4'(ovf[0]));
    check("out_b",  4'(out_b),  4'(ph[1] >= 1 && ph[1] <= on_c[1]));
    check("busy_b", 4'(busy_b), 4'(ph[1] != 0));
    check("pend_b", 4'(pend_b), 4'(pend[1]));
    check("ovf_b",  4'(ovf_b),  4'(ovf[1]));
    if (out_a && !prev_a) blinks++;
    prev_a = out_a;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0);
  endtask

  initial begin
    step(0, 1);
    step(0, 1);
    idle(2);
    step(1, 0);
    idle(10);
    step(1, 0); step(0, 0); step(1, 0); step(1, 0);
    idle(24);
    step(1, 0);
    idle(5);
    step(1, 0);
    idle(12);
    blinks = 0;
    for (int i = 0; i < 6; i++) step(1, 0);
    idle(40);
    check("held_blinks", 4'(blinks), 4'd4);
    step(1, 0); step(1, 0); step(1, 0);
    step(0, 1);
    step(1, 0);
    idle(10);
    step(1, 0); step(1, 0);
    idle(10);
    for (int i = 0; i < 500; i++) step($urandom_range(0, 3) == 0, $urandom_range(0, 99) == 0);
    for (int i = 0; i < 200; i++) step($urandom_range(0, 3) != 0, $urandom_range(0, 59) == 0);
    idle(30);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/my_pulse_replayer.md
# my_pulse_replayer

Converts single-cycle event pulses, such as those from the debounced push-button pulse generators, back into human-visible level pulses for LEDs or other indicators. Each input pulse produces one output blink of fixed width followed by a fixed dark gap. Pulses that arrive while a blink is in progress are counted and replayed in order, so no event is merged or silently lost. The block sits between the button/event logic and the LED or indicator outputs.

## Interface
- ON_CYCLES, default 4: width of each output blink in clock cycles; minimum 1.
- GAP_CYCLES, default 2: dark gap after each blink in clock cycles; minimum 1.
- PEND_WIDTH, default 2: width of the pending-event counter; maximum backlog is 2^PEND_WIDTH-1.
- rp_clock  input  1  single clock; all state changes on its rising edge.
- rp_reset  input  1  synchronous, active-high reset.
- pulse_in  input  1  event pulse; every high cycle counts as one event.
- rp_output  output  1  stretched blink, high only in the ON state.
- rp_busy  output  1  high whenever the state is not IDLE.
- rp_pending  output  PEND_WIDTH  events waiting to be replayed.
- rp_overflow  output  1  sticky flag; set when an event is dropped, cleared only by reset.

## Operation
- States:
  - IDLE = 0.
  - ON = 1.
  - GAP = 2.
- Registers: state, down-counter cnt, pending count, overflow flag.
- IDLE:
  - If pulse_in is high, go to ON with cnt = ON_CYCLES-1.
  - Otherwise stay in IDLE.
- ON:
  - If cnt == 0, go to GAP with cnt = GAP_CYCLES-1.
  - Otherwise cnt decrements.
- GAP:
  - If cnt == 0 and (pending > 0 or pulse_in is high), go to ON with cnt = ON_CYCLES-1.
  - If cnt == 0 and neither condition holds, go to IDLE.
  - Otherwise cnt decrements.
- Pending update, evaluated every cycle in ON or GAP:
  - A "consume" occurs on the GAP→ON transition when pending > 0.
  - pulse_in and consume together: pending is unchanged.
  - pulse_in alone: pending increments.
  - consume alone: pending decrements.
  - pulse_in at GAP end with pending == 0: the pulse starts the next blink directly and pending stays 0.
- Saturation: if pulse_in arrives with pending at its maximum and no consume, the pulse is dropped, pending holds, and rp_overflow is set.
- rp_output = (state == ON) and rp_busy = (state != IDLE), both decoded directly from registered state.
- Arithmetic: cnt width is clog2(max(ON_CYCLES, GAP_CYCLES)) with a minimum of 1 bit. pending never wraps.

## Timing
- Reset values: state IDLE, cnt 0, rp_output 0, rp_busy 0, rp_pending 0, rp_overflow 0.
- Reset wins over every other event in the same cycle. Reset in the middle of a blink forces rp_output low on the next cycle and discards the backlog.
- Latency: pulse_in sampled high at edge k puts rp_output high from edge k+1 through edge k+ON_CYCLES, then low for GAP_CYCLES cycles.
- One blink period is ON_CYCLES + GAP_CYCLES cycles.
- Back-to-back blinks are always separated by exactly GAP_CYCLES low cycles.
- rp_busy deasserts at the edge after the last GAP cycle when there is no backlog.
- A pulse_in held high for N cycles counts as N events, because the input is expected to be already single-pulsed.
- rp_pending reflects the update made at the most recent edge.

## Structure
- Shared package/header rp_defs holds:
  - state encodings RP_IDLE = 2'd0, RP_ON = 2'd1, RP_GAP = 2'd2;
  - a clog2 helper for sizing cnt.
- A single sub-module is natural: my_sat_updown_counter, parameterized width, with inc/dec inputs and saturating count/overflow outputs. It holds the pending and overflow logic.
- The FSM and cnt stay in the top module.

## Test plan
All scenarios use defaults (ON=4, GAP=2, PEND_WIDTH=2) unless stated.
- Single pulse at edge 0:
  - rp_output high at edges 1–4, low at 5–6.
  - rp_busy high at edges 1–6, low from edge 7.
  - rp_pending stays 0.
- Pulses at edges 0, 2 and 3:
  - rp_pending reads 1 at edge 3, then 2.
  - Three blinks starting at edges 1, 7 and 13, each 4 cycles high with 2 low between.
  - rp_pending reaches 0 at edge 13.
- Pulse exactly at the last GAP cycle (edge 6) with pending 0: next blink starts at edge 7 and rp_pending stays 0.
- pulse_in held high at edges 0–5:
  - one immediate blink;
  - rp_pending saturates at 3;
  - rp_overflow sets on the fifth pulse (edge 4) and stays set;
  - exactly 4 blinks total.
- rp_reset asserted at edge 2 during a blink with pending 2: at edge 3 all outputs are 0, including rp_overflow; a new pulse afterward blinks normally.
- ON_CYCLES=1, GAP_CYCLES=1, two pulses at edges 0 and 1: rp_output high at edges 1 and 3 only.
